// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the fetch unit's ROM port, control inputs and the instruction
//   register handshake toward decode/execute.
//
//   Handshake: ir_out/pc_out are meaningful only while ir_valid=1. A transfer
//   happens on a rising clk edge where ir_valid=1 and ir_ready=1. ir_valid
//   never depends combinationally on ir_ready, and while ir_valid=1 and
//   ir_ready=0 the offered ir_out/pc_out stay stable.
//
//   Ports (master = fetch unit side):
//     start        in   pulse, begin/restart fetching
//     pmem_add     out  ROM address (= PC)
//     pmem_data    in   ROM data, combinational from pmem_add
//     redirect     in   load redirect_pc and flush the IR
//     redirect_pc  in   redirect target
//     ir_out       out  registered instruction
//     ir_valid     out  ir_out holds an unconsumed instruction
//     ir_ready     in   consumer accepts ir_out this cycle
//     pc_out       out  address ir_out was fetched from
//     busy         out  FSM in RUN
//     halted       out  FSM in HALTED
//     instr_count  out  instructions issued since start, saturating
//     fsm_state    out  raw FSM state for debug (IDLE=0, RUN=1, HALTED=2)
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 8
);
    logic               start;
    logic [ADDR_W-1:0]  pmem_add;
    logic [INSTR_W-1:0] pmem_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ready;
    logic [ADDR_W-1:0]  pc_out;
    logic               busy;
    logic               halted;
    logic [CNT_W-1:0]   instr_count;
    logic [1:0]         fsm_state;

    modport master (
        input  start, pmem_data, redirect, redirect_pc, ir_ready,
        output pmem_add, ir_out, ir_valid, pc_out, busy, halted, instr_count, fsm_state
    );

    modport slave (
        output start, pmem_data, redirect, redirect_pc, ir_ready,
        input  pmem_add, ir_out, ir_valid, pc_out, busy, halted, instr_count, fsm_state
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch sequencer for a 2**ADDR_W-entry combinational program ROM. Holds
//   the PC and a one-entry instruction register offered to the consumer
//   with a valid/ready handshake. Accepts PC redirects (which flush the IR)
//   and stops when the fetched word carries the HALT opcode.
//
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous, active-high reset
//     bus    instr_fetch_unit_if.master (ROM port, control, IR handshake,
//            status and debug state)
module instr_fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                INSTR_W  = 32,
    parameter logic [4:0]        HALT_OP  = 5'b11111,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic [ADDR_W-1:0]  pc_out;
    logic               busy;
    logic               halted;
    logic [CNT_W-1:0]   instr_count;

    logic load;
    logic is_halt;

    // The IR can take a new word when it is empty or is being drained now.
    assign load    = !ir_valid || bus.ir_ready;
    assign is_halt = (bus.pmem_data[INSTR_W-1 -: 5] == HALT_OP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir_out      <= '0;
            ir_valid    <= 1'b0;
            pc_out      <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // No fetch in the entry cycle; first word loads next edge.
                    if (bus.start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (bus.redirect) begin
                        // Flush: the word at the old PC is discarded uncounted.
                        pc       <= bus.redirect_pc;
                        ir_valid <= 1'b0;
                    end else if (load) begin
                        if (is_halt) begin
                            // HALT is never presented; PC stays on the HALT word.
                            ir_valid <= 1'b0;
                            state    <= HALTED;
                            busy     <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            ir_out   <= bus.pmem_data;
                            pc_out   <= pc;
                            ir_valid <= 1'b1;
                            pc       <= pc + 1'b1;
                            if (instr_count != '1)
                                instr_count <= instr_count + 1'b1;
                        end
                    end
                end

                HALTED: begin
                    if (bus.start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                        pc          <= RESET_PC;
                        instr_count <= '0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_add    = pc;
    assign bus.ir_out      = ir_out;
    assign bus.ir_valid    = ir_valid;
    assign bus.pc_out      = pc_out;
    assign bus.busy        = busy;
    assign bus.halted      = halted;
    assign bus.instr_count = instr_count;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    logic [31:0] rom [0:31];

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational program ROM
    assign bus.pmem_data = rom[bus.pmem_add];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < 32; i++) rom[i] = 32'h0800_0000 | (i * 32'h0001_0101);
        rom[0]  = 32'h8040_0001;
        rom[11] = 32'hC1C0_0004;
        rom[12] = 32'hF800_0000;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready    = 1'b1;
        #2;
        chk("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy},     32'd0);
        chk("rst_halt",  {31'd0, bus.halted},   32'd0);
        chk("rst_cnt",   {24'd0, bus.instr_count}, 32'd0);
        chk("rst_add",   {27'd0, bus.pmem_add}, 32'd0);
        chk("rst_ir",    bus.ir_out, 32'd0);
        step();
        reset = 1'b0;

        // Redirect in IDLE is ignored
        bus.redirect = 1'b1; bus.redirect_pc = 5'd7;
        step();
        bus.redirect = 1'b0;
        chk("idle_redir_add",  {27'd0, bus.pmem_add}, 32'd0);
        chk("idle_redir_busy", {31'd0, bus.busy},     32'd0);

        // Straight-line program up to HALT
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy",  {31'd0, bus.busy},     32'd1);
        chk("start_nofetch", {31'd0, bus.ir_valid}, 32'd0);
        chk("start_state", {30'd0, bus.fsm_state}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("seq_valid", {31'd0, bus.ir_valid}, 32'd1);
            chk("seq_pc",    {27'd0, bus.pc_out},   i);
            chk("seq_ir",    bus.ir_out,            rom[i]);
        end
        step();
        chk("halt_halted", {31'd0, bus.halted},   32'd1);
        chk("halt_busy",   {31'd0, bus.busy},     32'd0);
        chk("halt_valid",  {31'd0, bus.ir_valid}, 32'd0);
        chk("halt_cnt",    {24'd0, bus.instr_count}, 32'd12);
        chk("halt_state",  {30'd0, bus.fsm_state}, 32'd2);

        // Redirect in HALTED is ignored
        bus.redirect = 1'b1; bus.redirect_pc = 5'd5;
        step();
        bus.redirect = 1'b0;
        chk("hlt_redir_add",  {27'd0, bus.pmem_add}, 32'd12);
        chk("hlt_redir_halt", {31'd0, bus.halted},   32'd1);

        // Restart from HALTED, stall, then redirect
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart_cnt", {24'd0, bus.instr_count}, 32'd0);
        chk("restart_add", {27'd0, bus.pmem_add},    32'd0);
        step();
        chk("restart_pc0", {27'd0, bus.pc_out}, 32'd0);
        step();
        step();
        chk("pre_stall_pc", {27'd0, bus.pc_out}, 32'd2);
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    {27'd0, bus.pc_out},   32'd2);
            chk("stall_ir",    bus.ir_out,            rom[2]);
            chk("stall_add",   {27'd0, bus.pmem_add}, 32'd3);
            chk("stall_valid", {31'd0, bus.ir_valid}, 32'd1);
        end
        bus.ir_ready = 1'b1;
        step();
        chk("unstall_pc", {27'd0, bus.pc_out}, 32'd3);
        step();
        chk("pre_redir_pc", {27'd0, bus.pc_out}, 32'd4);
        bus.redirect = 1'b1; bus.redirect_pc = 5'd9;
        step();
        bus.redirect = 1'b0;
        chk("redir_valid", {31'd0, bus.ir_valid},    32'd0);
        chk("redir_add",   {27'd0, bus.pmem_add},    32'd9);
        chk("redir_cnt",   {24'd0, bus.instr_count}, 32'd5);
        step();
        chk("redir_pc",  {27'd0, bus.pc_out},    32'd9);
        chk("redir_ir",  bus.ir_out,             rom[9]);
        chk("redir_cnt2", {24'd0, bus.instr_count}, 32'd6);
        step();
        step();
        chk("pre_halt2_pc", {27'd0, bus.pc_out}, 32'd11);
        step();
        chk("halt2", {31'd0, bus.halted}, 32'd1);
        chk("halt2_cnt", {24'd0, bus.instr_count}, 32'd8);

        // No HALT anywhere: wrap and saturation
        rom[12] = 32'h1234_5678;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 5'd31;
        step();
        bus.redirect = 1'b0;
        chk("wrap_add", {27'd0, bus.pmem_add}, 32'd31);
        step();
        chk("wrap_pc31", {27'd0, bus.pc_out},   32'd31);
        chk("wrap_ir31", bus.ir_out,            rom[31]);
        chk("wrap_add0", {27'd0, bus.pmem_add}, 32'd0);
        step();
        chk("wrap_pc0", {27'd0, bus.pc_out}, 32'd0);
        chk("wrap_cnt", {24'd0, bus.instr_count}, 32'd2);
        for (int i = 0; i < 300; i++) step();
        chk("sat_cnt",   {24'd0, bus.instr_count}, 32'd255);
        chk("sat_valid", {31'd0, bus.ir_valid},    32'd1);

        // Asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.ir_valid},    32'd0);
        chk("arst_busy",  {31'd0, bus.busy},        32'd0);
        chk("arst_cnt",   {24'd0, bus.instr_count}, 32'd0);
        chk("arst_add",   {27'd0, bus.pmem_add},    32'd0);
        #1;
        reset = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("post_rst_pc",    {27'd0, bus.pc_out},   32'd0);
        chk("post_rst_ir",    bus.ir_out,            rom[0]);
        chk("post_rst_valid", {31'd0, bus.ir_valid}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch sequencer that drives the address port of the 32-entry combinational program ROM and consumes its instruction word. It holds the program counter and a one-entry instruction register (IR) with a valid/ready handshake toward decode/execute. It accepts PC redirects and stops on the HALT opcode.

Parameters:
ADDR_W, 5, program-memory address width (ROM depth 2**ADDR_W)
INSTR_W, 32, instruction width
HALT_OP, 5'b11111, opcode value in instr[INSTR_W-1:INSTR_W-5] that stops fetching
RESET_PC, 0, start address after reset/restart
CNT_W, 8, width of issued-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins or restarts fetching
pmem_add  output  ADDR_W  ROM read address (= current PC)
pmem_data  input  INSTR_W  ROM read data, combinational from pmem_add
redirect  input  1  load new PC and flush IR
redirect_pc  input  ADDR_W  redirect target
ir_out  output  INSTR_W  registered instruction
ir_valid  output  1  ir_out holds an unconsumed instruction
ir_ready  input  1  consumer accepts ir_out this cycle
pc_out  output  ADDR_W  address ir_out was fetched from
busy  output  1  state == RUN
halted  output  1  state == HALTED
instr_count  output  CNT_W  instructions issued since start, saturating

Behaviour:
- Reset (async, immediate): state IDLE, pc=RESET_PC, ir_out=0, ir_valid=0, pc_out=0, busy=0, halted=0, instr_count=0. Reset mid-operation discards the IR contents.
- pmem_add = pc at all times; ROM data is sampled in the same cycle.
- States: IDLE, RUN, HALTED.
- IDLE: start -> RUN. Redirect is ignored. No fetch occurs in the transition cycle.
- RUN, per edge, in priority order:
  1. redirect=1: pc<=redirect_pc, ir_valid<=0, no load, instr_count unchanged. Any accept in that cycle still completes on the consumer side.
  2. load = !ir_valid || ir_ready. If load and pmem_data opcode == HALT_OP: ir_valid<=0, pc unchanged, state->HALTED. The HALT word is never presented on ir_out.
  3. Otherwise, if load: ir_out<=pmem_data, pc_out<=pc, ir_valid<=1, pc<=pc+1 mod 2**ADDR_W (31 -> 0), instr_count<=instr_count+1, saturating at all-ones.
  4. No load (ir_valid && !ir_ready): ir_out, pc_out, pc and ir_valid hold.
  - start is ignored in RUN.
- Throughput: one instruction per cycle when ir_ready=1. First ir_valid rises one edge after the edge that enters RUN, i.e. start at edge k gives ir_valid=1 after edge k+1.
- HALTED: ir_valid=0; redirect is ignored. start -> RUN with pc<=RESET_PC and instr_count<=0.
- ir_out and pc_out retain their last values when ir_valid=0; the consumer must not sample them while ir_valid=0.

Test Plan:
- ROM[0..11] = non-HALT words (ROM[0]=32'h80400001 … ROM[11]=32'hC1C00004), ROM[12]=32'hF8000000; reset, start, ir_ready=1 -> pc_out 0..11 on 12 consecutive valid cycles with matching ir_out; then halted=1, busy=0, instr_count=12, HALT word never valid.
- Same program, ir_ready=0 for 3 cycles while pc_out=2 -> ir_out=ROM[2] and pmem_add=3 held stable; ir_ready=1 -> pc_out 3 next cycle, no instruction lost or duplicated.
- redirect=1, redirect_pc=9 while ir_valid=1 with pc_out=4 -> ir_valid=0 next cycle, then pc_out=9 and ir_out=ROM[9]; instr_count excludes the flushed fetch.
- ROM all non-HALT; redirect_pc=31 -> pc_out 31 then 0 (wrap); run 300 issues -> instr_count saturates at 255.
- Assert reset between edges mid-RUN -> ir_valid, busy, instr_count and pmem_add go to 0 without waiting for clk; start afterwards fetches from 0.
- After HALTED, pulse start -> instr_count=0, pc_out=0 on first valid; redirect pulsed in IDLE or HALTED -> no effect.
